// File: rtl/sd_clk_monitor_pkg.sv
// Shared SD defines: monitor defaults and FSM state encoding.
package sd_clk_monitor_pkg;

    localparam int unsigned SD_LOCK_COUNT = 4;
    localparam int unsigned SD_TIMEOUT    = 1024;
    localparam int unsigned SD_MAX_HALF   = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        TRACK   = 2'd3
    } sd_state_e;

endpackage

// File: rtl/sd_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sd_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d_in,
    output logic d_out
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_in;
            s2_q <= s1_q;
        end
    end

    assign d_out = s2_q;

endmodule

// File: rtl/sd_clk_monitor.sv
// SD clock monitor: recovers the card-clock divider from edge spacing,
// reports lock, stop, mismatch and out-of-range intervals.
module sd_clk_monitor
    import sd_clk_monitor_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = SD_LOCK_COUNT,
    parameter int unsigned TIMEOUT    = SD_TIMEOUT,
    parameter int unsigned MAX_HALF   = SD_MAX_HALF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       SD_CLK_IN,
    output logic [7:0] DIV_OUT,
    output logic       LOCKED,
    output logic       STOPPED,
    output logic       MISMATCH,
    output logic       RANGE_ERR
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(MAX_HALF + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);

    sd_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] cand_q, cand_d;
    logic cand_ok_q, cand_ok_d;
    logic [MW-1:0] match_q, match_d;
    logic [7:0] div_q, div_d;
    logic locked_q, locked_d;
    logic stopped_q, stopped_d;
    logic mismatch_q, mismatch_d;
    logic range_err_q, range_err_d;
    logic prev_q;
    logic sync;
    logic strobe;
    logic too_long;
    logic same;

    sd_sync2 u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .d_in (SD_CLK_IN),
        .d_out(sync)
    );

    assign strobe   = sync ^ prev_q;
    // cnt_q on a strobe cycle is exactly the interval just completed
    assign too_long = cnt_q > CW'(MAX_HALF);
    assign same     = cand_ok_q && (cnt_q == CW'(cand_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        cand_ok_d   = cand_ok_q;
        match_d     = match_q;
        div_d       = div_q;
        locked_d    = locked_q;
        stopped_d   = stopped_q;
        mismatch_d  = 1'b0;
        range_err_d = 1'b0;

        if (state_q != IDLE) begin
            if (strobe) begin
                cnt_d = CW'(1);
            end else if (cnt_q != CW'(TIMEOUT)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        unique case (state_q)
            IDLE: state_d = ACQUIRE;
            ACQUIRE: begin
                if (strobe) begin
                    state_d   = MEASURE;
                    stopped_d = 1'b0;
                end
            end
            MEASURE, TRACK: begin
                if (strobe) begin
                    if (too_long) begin
                        range_err_d = 1'b1;
                        match_d     = '0;
                        locked_d    = 1'b0;
                        state_d     = MEASURE;
                    end else if (same) begin
                        if (state_q == MEASURE) begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        mismatch_d = cand_ok_q;
                        cand_d     = HW'(cnt_q);
                        cand_ok_d  = 1'b1;
                        match_d    = MW'(1);
                        locked_d   = 1'b0;
                        state_d    = MEASURE;
                    end
                    if (state_d == MEASURE &&
                        match_d == MW'(LOCK_COUNT)) begin
                        div_d    = 8'(cand_d - HW'(1));
                        locked_d = 1'b1;
                        state_d  = TRACK;
                    end
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    stopped_d = 1'b1;
                    locked_d  = 1'b0;
                    cand_ok_d = 1'b0;
                    match_d   = '0;
                    state_d   = ACQUIRE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable wins over everything except the held divider
        if (!EN) begin
            state_d     = IDLE;
            cnt_d       = '0;
            cand_ok_d   = 1'b0;
            match_d     = '0;
            locked_d    = 1'b0;
            stopped_d   = 1'b0;
            mismatch_d  = 1'b0;
            range_err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            cand_ok_q   <= 1'b0;
            match_q     <= '0;
            div_q       <= '0;
            locked_q    <= 1'b0;
            stopped_q   <= 1'b0;
            mismatch_q  <= 1'b0;
            range_err_q <= 1'b0;
            prev_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            cand_ok_q   <= cand_ok_d;
            match_q     <= match_d;
            div_q       <= div_d;
            locked_q    <= locked_d;
            stopped_q   <= stopped_d;
            mismatch_q  <= mismatch_d;
            range_err_q <= range_err_d;
            prev_q      <= sync;
        end
    end

    assign DIV_OUT   = div_q;
    assign LOCKED    = locked_q;
    assign STOPPED   = stopped_q;
    assign MISMATCH  = mismatch_q;
    assign RANGE_ERR = range_err_q;

endmodule

// File: tb/tb_sd_clk_monitor.sv
// Bench for sd_clk_monitor: directed scenarios plus random segments,
// every cycle compared against an interval-level reference model.
module tb_sd_clk_monitor;

    localparam int LC = 4;
    localparam int TO = 1024;
    localparam int MH = 256;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic EN = 1'b0;
    logic SD_CLK_IN = 1'b0;
    logic [7:0] DIV_OUT;
    logic LOCKED;
    logic STOPPED;
    logic MISMATCH;
    logic RANGE_ERR;

    int n_checks = 0;
    int n_fail = 0;

    sd_clk_monitor dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .SD_CLK_IN(SD_CLK_IN),
        .DIV_OUT  (DIV_OUT),
        .LOCKED   (LOCKED),
        .STOPPED  (STOPPED),
        .MISMATCH (MISMATCH),
        .RANGE_ERR(RANGE_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d",
                     tag, $time, obs, exp);
        end
    endtask

    // SD clock generator: a new half-period takes effect at a toggle
    int half_per = 5;
    int next_half = 5;
    int gcnt = 0;
    bit gen_on = 1'b0;

    initial forever begin
        @(negedge CLK);
        #1;
        if (gen_on) begin
            gcnt++;
            if (gcnt >= half_per) begin
                SD_CLK_IN = ~SD_CLK_IN;
                gcnt = 0;
                half_per = next_half;
            end
        end
    end

    // Reference model: works on input history and interval lengths
    typedef enum {P_OFF, P_WAIT, P_HUNT, P_LOCK} ph_e;
    ph_e ph = P_OFF;
    int k = 0;
    int last = 0;
    int cand = 0;
    int hits = 0;
    int m_div = 0;
    bit cand_ok = 1'b0;
    bit m_locked = 1'b0;
    bit m_stopped = 1'b0;
    bit m_mm = 1'b0;
    bit m_re = 1'b0;
    bit [2:0] smp = '0;

    always @(posedge CLK) begin
        bit strobe;
        int n;
        m_mm = 1'b0;
        m_re = 1'b0;
        k++;
        if (RST) begin
            ph = P_OFF;
            smp = '0;
            cand_ok = 1'b0;
            hits = 0;
            m_locked = 1'b0;
            m_stopped = 1'b0;
            m_div = 0;
        end else begin
            // an input change is seen as an interval boundary 2 edges on
            strobe = smp[1] != smp[2];
            smp = {smp[1], smp[0], SD_CLK_IN};
            if (!EN) begin
                ph = P_OFF;
                cand_ok = 1'b0;
                hits = 0;
                m_locked = 1'b0;
                m_stopped = 1'b0;
            end else if (ph == P_OFF) begin
                ph = P_WAIT;
            end else if (ph == P_WAIT) begin
                if (strobe) begin
                    ph = P_HUNT;
                    m_stopped = 1'b0;
                    last = k;
                end
            end else if (strobe) begin
                n = k - last;
                if (n > TO) n = TO;
                last = k;
                if (n > MH) begin
                    m_re = 1'b1;
                    hits = 0;
                    m_locked = 1'b0;
                    ph = P_HUNT;
                end else if (cand_ok && n == cand) begin
                    if (ph == P_HUNT) hits++;
                end else begin
                    m_mm = cand_ok;
                    cand = n;
                    cand_ok = 1'b1;
                    hits = 1;
                    m_locked = 1'b0;
                    ph = P_HUNT;
                end
                if (ph == P_HUNT && hits == LC) begin
                    m_div = cand - 1;
                    m_locked = 1'b1;
                    ph = P_LOCK;
                end
            end else if (k - last >= TO) begin
                m_stopped = 1'b1;
                m_locked = 1'b0;
                cand_ok = 1'b0;
                hits = 0;
                ph = P_WAIT;
            end
        end
    end

    bit stop_prev = 1'b0;
    bit locked_ever = 1'b0;
    int stop_gap = -1;
    int mm_seen = 0;
    int re_seen = 0;
    int div_at_mm = -1;
    int locked_at_mm = -1;

    always @(negedge CLK) begin
        check("DIV_OUT", 32'(DIV_OUT), m_div);
        check("LOCKED", 32'(LOCKED), 32'(m_locked));
        check("STOPPED", 32'(STOPPED), 32'(m_stopped));
        check("MISMATCH", 32'(MISMATCH), 32'(m_mm));
        check("RANGE_ERR", 32'(RANGE_ERR), 32'(m_re));
        if (MISMATCH === 1'b1) begin
            mm_seen++;
            div_at_mm = int'(DIV_OUT);
            locked_at_mm = int'(LOCKED);
        end
        if (RANGE_ERR === 1'b1) re_seen++;
        if (LOCKED === 1'b1) locked_ever = 1'b1;
        if (STOPPED === 1'b1 && !stop_prev) stop_gap = k - last;
        stop_prev = (STOPPED === 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
        #2;
    endtask

    initial begin
        cyc(3);
        check("rst_div", 32'(DIV_OUT), 0);
        check("rst_locked", 32'(LOCKED), 0);
        check("rst_stopped", 32'(STOPPED), 0);
        RST = 1'b0;
        cyc(2);

        // divider 4
        EN = 1'b1;
        gen_on = 1'b1;
        cyc(60);
        check("d4_locked", 32'(LOCKED), 1);
        check("d4_div", 32'(DIV_OUT), 4);
        check("d4_no_mm", mm_seen, 0);

        // change to 10-cycle half-period
        next_half = 10;
        cyc(100);
        check("d9_mm_count", mm_seen, 1);
        check("d9_mm_unlock", locked_at_mm, 0);
        check("d9_mm_hold", div_at_mm, 4);
        check("d9_locked", 32'(LOCKED), 1);
        check("d9_div", 32'(DIV_OUT), 9);

        // stopped clock
        gen_on = 1'b0;
        cyc(1100);
        check("stop_set", 32'(STOPPED), 1);
        check("stop_unlock", 32'(LOCKED), 0);
        check("stop_gap", stop_gap, TO);
        half_per = 5;
        next_half = 5;
        gcnt = 0;
        gen_on = 1'b1;
        cyc(12);
        check("stop_clear", 32'(STOPPED), 0);
        cyc(40);
        check("restart_lock", 32'(LOCKED), 1);
        check("restart_div", 32'(DIV_OUT), 4);

        // out-of-range half-period
        next_half = 300;
        cyc(400);
        re_seen = 0;
        locked_ever = 1'b0;
        cyc(1800);
        check("range_pulses", 32'(re_seen >= 5), 1);
        check("range_nolock", 32'(locked_ever), 0);

        // divider 0
        half_per = 1;
        next_half = 1;
        cyc(40);
        check("d0_locked", 32'(LOCKED), 1);
        check("d0_div", 32'(DIV_OUT), 0);

        // reset while locked, then EN drop while locked
        half_per = 5;
        next_half = 5;
        cyc(60);
        check("pre_rst_lock", 32'(LOCKED), 1);
        RST = 1'b1;
        #1;
        check("rst_lock_div", 32'(DIV_OUT), 0);
        check("rst_lock_locked", 32'(LOCKED), 0);
        check("rst_lock_stop", 32'(STOPPED), 0);
        check("rst_lock_mm", 32'(MISMATCH), 0);
        check("rst_lock_re", 32'(RANGE_ERR), 0);
        cyc(3);
        RST = 1'b0;
        cyc(60);
        check("relock", 32'(LOCKED), 1);
        check("relock_div", 32'(DIV_OUT), 4);
        EN = 1'b0;
        cyc(2);
        check("en_off_lock", 32'(LOCKED), 0);
        check("en_off_div", 32'(DIV_OUT), 4);
        check("en_off_stop", 32'(STOPPED), 0);
        EN = 1'b1;

        // random segments, checked cycle by cycle against the model
        for (int s = 0; s < 30; s++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                RST = 1'b1;
                cyc(2);
                RST = 1'b0;
            end else if (r < 3) begin
                EN = 1'b0;
                cyc($urandom_range(1, 5));
                EN = 1'b1;
            end else if (r == 3) begin
                gen_on = 1'b0;
                cyc($urandom_range(900, 1150));
                gen_on = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) next_half = 300;
            else next_half = $urandom_range(1, 12);
            cyc($urandom_range(40, 200));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_clk_monitor.md
SD_CLK_MONITOR -- requirements
Module: sd_clk_monitor

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive equal half-period intervals required for lock.
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the CLK cycles without an SD clock edge before STOPPED asserts.
REQ-003 SHALL have parameter MAX_HALF, default 256, meaning the largest legal half-period in CLK cycles (divider 255).
REQ-004 SHALL have port CLK, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port EN, input, 1 bit: monitor enable, synchronous to CLK.
REQ-007 SHALL have port SD_CLK_IN, input, 1 bit: observed SD clock, asynchronous to CLK.
REQ-008 SHALL have port DIV_OUT, output, 8 bits: recovered divider value (half-period minus 1).
REQ-009 SHALL have port LOCKED, output, 1 bit: DIV_OUT is valid and tracking.
REQ-010 SHALL have port STOPPED, output, 1 bit: no SD clock edge seen for TIMEOUT cycles.
REQ-011 SHALL have port MISMATCH, output, 1 bit: one-cycle pulse when an interval differs from the locked or candidate value.
REQ-012 SHALL have port RANGE_ERR, output, 1 bit: one-cycle pulse when a measured interval exceeds MAX_HALF.

Function
REQ-013 SHALL pass SD_CLK_IN through a 2-flop synchronizer, then an edge register; EDGE strobe = synchronized XOR previous; the strobe appears 3 CLK cycles after an input transition; rising and falling edges are both counted.
REQ-014 SHALL define interval N = number of CLK cycles between consecutive EDGE strobes; the interval counter loads 1 on a strobe, otherwise increments, and saturates at TIMEOUT.
REQ-015 SHALL use FSM states IDLE, ACQUIRE, MEASURE and TRACK.
REQ-016 SHALL move to IDLE from any state when EN=0; IDLE clears the counters, LOCKED and STOPPED, and holds DIV_OUT.
REQ-017 SHALL transition IDLE -> ACQUIRE when EN=1; ACQUIRE -> MEASURE on the first strobe (no interval is recorded).
REQ-018 SHALL, in MEASURE, on each strobe: if N > MAX_HALF, pulse RANGE_ERR, clear the match count and stay; else if N equals the candidate, increment the match count; else load the candidate with N, reset the match count to 1 and pulse MISMATCH only when the previous candidate was valid.
REQ-019 SHALL, when the match count reaches LOCK_COUNT, load DIV_OUT = candidate-1 (8 bits, exact since N <= 256), set LOCKED the next cycle and enter TRACK.
REQ-020 SHALL, in TRACK, keep LOCKED on each strobe with N equal to the candidate; any other N pulses MISMATCH (or RANGE_ERR if N > MAX_HALF), clears LOCKED, holds DIV_OUT at its last locked value, and returns to MEASURE with the candidate = N (if legal) and the match count = 1.
REQ-021 SHALL, when the counter reaches TIMEOUT in MEASURE or TRACK, set STOPPED, clear LOCKED and enter ACQUIRE; STOPPED clears on the next strobe.
REQ-022 SHALL give RANGE_ERR priority over MISMATCH when both conditions arise on one strobe; at most one pulse fires per strobe.

Reset
REQ-023 SHALL, on RST, force the FSM to IDLE, clear the synchronizer, edge register and counters, and drive DIV_OUT=0, LOCKED=0, STOPPED=0, MISMATCH=0 and RANGE_ERR=0 immediately; reset mid-lock discards all state.

Structure
REQ-024 SHALL place the FSM state encoding and the defaults LOCK_COUNT, TIMEOUT and MAX_HALF in the shared SD defines package.
REQ-025 SHALL implement the 2-flop synchronizer as sub-module sd_sync2; all other logic is flat.

Verification
REQ-026 SHALL test: SD_CLK_IN toggling every 5 CLK (divider 4), EN=1 -> LOCKED=1 after the 5th strobe, DIV_OUT=4, no MISMATCH.
REQ-027 SHALL test: toggling every CLK cycle (divider 0, synchronous stimulus) -> LOCKED=1, DIV_OUT=0.
REQ-028 SHALL test: divider 4 locked, then switch to a 10-cycle half-period -> one MISMATCH pulse, LOCKED=0 with DIV_OUT held at 4, then relock with DIV_OUT=9.
REQ-029 SHALL test: locked, then SD_CLK_IN held constant -> STOPPED=1 and LOCKED=0 exactly 1024 cycles after the last strobe; toggling resumes -> STOPPED clears on the first strobe.
REQ-030 SHALL test: 300-cycle half-period -> RANGE_ERR pulse on each strobe and LOCKED never asserts.
REQ-031 SHALL test: RST asserted while locked at divider 4, and EN dropped while locked -> all outputs 0 after RST; after EN drop, LOCKED=0 with DIV_OUT still 4.
